// File: rtl/prog_done_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_done_ctrl
// Brief    : Run/done handshake for the 3BC core: PC load, run enable, halt
//            drain, Ack, per-program cycle count and optional watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module prog_done_ctrl #(
  parameter int PC_W         = 10,
  parameter int NUM_PROGS    = 3,
  parameter int START_ADDR_0 = 0,
  parameter int START_ADDR_1 = 256,
  parameter int START_ADDR_2 = 512,
  parameter int DRAIN_CYCLES = 2,
  parameter int CYC_W        = 16,
  parameter int MAX_CYCLES   = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         HaltDetect,
  output logic                         CountEn,
  output logic                         PCLoad,
  output logic [PC_W-1:0]              PCLoadAddr,
  output logic                         Ack,
  output logic                         Timeout,
  output logic [$clog2(NUM_PROGS)-1:0] ProgIdx,
  output logic [CYC_W-1:0]             CycleCount
);

  localparam int                   c_IDX_W      = $clog2(NUM_PROGS);
  localparam int                   c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_PROGS - 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CYC_W-1:0]     c_CYC_MAX    = '1;
  localparam logic [CYC_W-1:0]     c_WD_LAST    = CYC_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_ack;
  logic                 r_timeout;
  logic [c_IDX_W-1:0]   r_idx;
  logic [CYC_W-1:0]     r_cyc;
  logic [c_DRAIN_W-1:0] r_drain_cnt;
  logic                 w_wd_hit;
  logic                 w_drain_last;

  assign w_wd_hit     = (MAX_CYCLES != 0) && (r_cyc == c_WD_LAST);
  assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_ARMED;
      S_ARMED: if (!Start) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN: begin
        // Halt outranks the watchdog when both fire in the same cycle.
        if (HaltDetect)    w_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        else if (w_wd_hit) w_next = S_DONE;
      end
      S_DRAIN: if (w_drain_last) w_next = S_DONE;
      S_DONE:  if (Start) w_next = S_ARMED;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_timeout   <= 1'b0;
      r_idx       <= '0;
      r_cyc       <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_DONE);

      if (r_state == S_LOAD) begin
        r_cyc     <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (r_cyc != c_CYC_MAX) r_cyc <= r_cyc + 1'b1;
        r_timeout <= !HaltDetect && w_wd_hit;
      end

      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                    r_drain_cnt <= '0;

      if ((w_next == S_DONE) && (r_state != S_DONE))
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    PCLoadAddr = '0;
    if (r_idx == c_IDX_W'(0))      PCLoadAddr = PC_W'(START_ADDR_0);
    else if (r_idx == c_IDX_W'(1)) PCLoadAddr = PC_W'(START_ADDR_1);
    else if (r_idx == c_IDX_W'(2)) PCLoadAddr = PC_W'(START_ADDR_2);
  end

  assign CountEn    = (r_state == S_RUN);
  assign PCLoad     = (r_state == S_LOAD);
  assign Ack        = r_ack;
  assign Timeout    = r_timeout;
  assign ProgIdx    = r_idx;
  assign CycleCount = r_cyc;

endmodule
`default_nettype wire

// File: doc/prog_done_ctrl.md
Name: prog_done_ctrl

Overview:
- Completion side of the testbench run/done handshake for the 3BC processor. The testbench raises Start and releases it; this block loads the PC and enables counting. When the core decodes a halt, the block drains the pipeline and returns Ack.
- Also counts execution cycles per program and steps through NUM_PROGS programs, one per Start handshake.
- Sits between the testbench and the PC, alongside the PC count-enable logic.

Parameters:
- PC_W, 10: width of PC and start addresses.
- NUM_PROGS, 3: number of programs; ProgIdx wraps at NUM_PROGS.
- START_ADDR_0, 0: PC start address for program 0.
- START_ADDR_1, 256: PC start address for program 1.
- START_ADDR_2, 512: PC start address for program 2.
- DRAIN_CYCLES, 2: cycles between halt detect and Ack.
- CYC_W, 16: CycleCount width.
- MAX_CYCLES, 0: watchdog limit in run cycles; 0 disables the watchdog.

Ports:
- Clk, in, 1: clock.
- Reset, in, 1: synchronous, active-high reset.
- Start, in, 1: from testbench; held high at least 1 cycle, program begins on release.
- HaltDetect, in, 1: from decoder; 1 while a halt instruction is in decode.
- CountEn, out, 1: PC increment enable.
- PCLoad, out, 1: one-cycle PC load strobe.
- PCLoadAddr, out, PC_W: start address for the current ProgIdx.
- Ack, out, 1: program finished; to testbench.
- Timeout, out, 1: the last program ended by watchdog.
- ProgIdx, out, $clog2(NUM_PROGS): index of the current/next program.
- CycleCount, out, CYC_W: number of RUN cycles of the current/last program.

Behaviour:
- States: IDLE, ARMED, LOAD, RUN, DRAIN, DONE.
- Reset (takes priority in any state, mid-run included) clears all outputs to 0 and sets state to IDLE on the next edge:
  - CountEn=0, PCLoad=0, Ack=0, Timeout=0, ProgIdx=0, CycleCount=0.
- IDLE:
  - Start=1 -> ARMED.
- ARMED:
  - Stay while Start=1.
  - Start=0 -> LOAD.
- LOAD (exactly 1 cycle):
  - PCLoad=1 and PCLoadAddr=START_ADDR_<ProgIdx>.
  - CycleCount cleared; Timeout cleared.
  - Next state is RUN.
- PCLoadAddr is combinational from ProgIdx in all states.
- RUN:
  - CountEn=1 combinationally while in RUN.
  - CycleCount increments by 1 per cycle and saturates at its maximum; it does not wrap.
  - HaltDetect=1 -> DRAIN. CountEn is 0 from the following cycle; the halt cycle itself is counted.
  - If MAX_CYCLES!=0 and CycleCount==MAX_CYCLES-1 with no halt -> DONE with Timeout=1, skipping DRAIN.
  - Halt and watchdog in the same cycle: halt wins and Timeout=0.
- DRAIN:
  - Counts DRAIN_CYCLES cycles with CountEn=0, then -> DONE.
  - DRAIN_CYCLES=0 goes straight to DONE.
  - HaltDetect is ignored outside RUN.
- DONE:
  - Ack=1 as a registered output, asserted in the first DONE cycle.
  - On DONE entry, ProgIdx increments, wrapping from NUM_PROGS-1 to 0.
  - CycleCount and Timeout hold.
  - Ack stays 1 until Start=1; then Ack drops on that edge and state -> ARMED.
- Start=1 during LOAD, RUN or DRAIN is ignored; no restart mid-program.
- Start held continuously from reset: the block stays in ARMED and issues no load until Start falls.
- CountEn=0 and PCLoad=0 in every state except as stated above.
- Latency from Start falling edge:
  - PCLoad asserted in the cycle after the edge.
  - CountEn asserted 2 cycles after the edge.

Test Plan:
- Reset, then Start high 3 cycles, then low:
  - PCLoad pulses exactly 1 cycle with PCLoadAddr=0.
  - CountEn=1 from the next cycle; Ack=0.
- Program 0 runs 20 cycles, then HaltDetect for 1 cycle:
  - CountEn falls the next cycle.
  - Ack rises 2 cycles later (DRAIN_CYCLES=2).
  - CycleCount=21; ProgIdx=1; Timeout=0.
- Three full handshakes back-to-back:
  - PCLoadAddr sequence is 0, 256, 512.
  - ProgIdx wraps to 0 after the third Ack.
  - Ack drops on each Start rise.
- MAX_CYCLES=50, HaltDetect never asserted:
  - DONE after 50 RUN cycles with Ack=1, Timeout=1, CycleCount=50, no DRAIN.
- Reset asserted mid-RUN (cycle 10):
  - Next edge gives CountEn=0, Ack=0, ProgIdx=0, CycleCount=0, state IDLE.
  - A following Start restarts at address 0.
- Glitch cases:
  - Start pulsed during RUN, and HaltDetect asserted during DRAIN/DONE: no state change, no extra PCLoad, ProgIdx increments only once.
